// File: rtl/mod_alu_pkg.sv
// rtl/mod_alu_pkg.sv - op encoding and Kyber constants shared by the modular ALU pipeline
package mod_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_RED = 2'b11
    } op_e;

    localparam int KYBER_Q      = 3329;
    localparam int KYBER_QINV   = 3327;
    // R mod Q for R = 2^16; a Montgomery multiply by this value is the identity
    localparam int MONT_R_MOD_Q = 2285;

endpackage

// File: rtl/mod_alu_pipe_mont_reduce_stage.sv
// rtl/mod_alu_pipe_mont_reduce_stage.sv - Montgomery reduction of p to u in [0, 2Q)
// The t*Q and p registers form pipeline stage 2; u is formed combinationally for stage 3.
module mont_reduce_stage #(
    parameter int W    = 16,
    parameter int Q    = 3329,
    parameter int QINV = 3327
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [2*W-1:0] p_in,
    output logic [W:0]     u,
    output logic [W:0]     p_lo
);
    localparam int W1 = W + 1;
    localparam logic [W-1:0] Q_W    = W'(Q);
    localparam logic [W-1:0] QINV_W = W'(QINV);

    logic [W-1:0]   t;
    logic [2*W-1:0] tq_q, tq_d;
    logic [2*W-1:0] p_q, p_d;

    always_comb begin
        t    = p_in[W-1:0] * QINV_W;
        tq_d = en ? ({{W{1'b0}}, t} * {{W{1'b0}}, Q_W}) : tq_q;
        p_d  = en ? p_in : p_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tq_q <= '0;
            p_q  <= '0;
        end else begin
            tq_q <= tq_d;
            p_q  <= p_d;
        end
    end

    // p + t*Q is a multiple of 2^W by construction, and needs one extra bit
    assign u    = W1'(({1'b0, p_q} + {1'b0, tq_q}) >> W);
    assign p_lo = p_q[W:0];

endmodule

// File: rtl/mod_alu_pipe.sv
// rtl/mod_alu_pipe.sv - three-stage modular add/sub/Montgomery mul/reduce pipeline, valid/ready
// Optional operand range flag enabled by MOD_ALU_RANGE_CHECK_EN.
import mod_alu_pkg::*;

module mod_alu_pipe #(
    parameter int W     = 16,
    parameter int Q     = KYBER_Q,
    parameter int QINV  = KYBER_QINV,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);
    localparam int W1 = W + 1;
    localparam logic [W:0] Q_W1 = W1'(Q);

    logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic             rdy1, rdy2, rdy3, ld1, ld2, ld3;
    op_e              op_in, op1_q, op1_d, op2_q, op2_d;
    logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
    logic [W:0]       sum_in, diff_in;
    logic [2*W-1:0]   raw_in, raw1_q, raw1_d;
    logic [W:0]       u2, p2_lo;
    logic [W-1:0]     res3, data3_q, data3_d;

    // Each stage loads when empty or when its successor takes its content
    always_comb begin
        rdy3 = !v3_q || out_ready;
        rdy2 = !v2_q || rdy3;
        rdy1 = !v1_q || rdy2;
        ld1  = rdy1 && in_valid;
        ld2  = rdy2 && v1_q;
        ld3  = rdy3 && v2_q;
        v1_d = rdy1 ? in_valid : v1_q;
        v2_d = rdy2 ? v1_q : v2_q;
        v3_d = rdy3 ? v2_q : v3_q;
    end

    always_comb begin
        op_in   = op_e'(in_op);
        sum_in  = {1'b0, in_a} + {1'b0, in_b};
        diff_in = {1'b0, in_a} - {1'b0, in_b};
        case (op_in)
            OP_ADD:  raw_in = {{(W-1){1'b0}}, sum_in};
            OP_SUB:  raw_in = {{(W-1){1'b0}}, diff_in};
            OP_MUL:  raw_in = {{W{1'b0}}, in_a} * {{W{1'b0}}, in_b};
            default: raw_in = {{W{1'b0}}, in_a};
        endcase
        op1_d  = ld1 ? op_in  : op1_q;
        tag1_d = ld1 ? in_tag : tag1_q;
        raw1_d = ld1 ? raw_in : raw1_q;
        op2_d  = ld2 ? op1_q  : op2_q;
        tag2_d = ld2 ? tag1_q : tag2_q;
    end

    mont_reduce_stage #(
        .W    (W),
        .Q    (Q),
        .QINV (QINV)
    ) u_mont (
        .clk  (clk),
        .rst  (rst),
        .en   (ld2),
        .p_in (raw1_q),
        .u    (u2),
        .p_lo (p2_lo)
    );

    // ADD/SUB ride the same stage-2 p register so all ops keep issue order
    always_comb begin
        case (op2_q)
            OP_ADD:  res3 = (p2_lo >= Q_W1) ? W'(p2_lo - Q_W1) : W'(p2_lo);
            OP_SUB:  res3 = p2_lo[W] ? W'(p2_lo + Q_W1) : W'(p2_lo);
            default: res3 = (u2 >= Q_W1) ? W'(u2 - Q_W1) : W'(u2);
        endcase
        data3_d = ld3 ? res3   : data3_q;
        tag3_d  = ld3 ? tag2_q : tag3_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            op1_q   <= OP_ADD;
            op2_q   <= OP_ADD;
            tag1_q  <= '0;
            tag2_q  <= '0;
            tag3_q  <= '0;
            raw1_q  <= '0;
            data3_q <= '0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            tag1_q  <= tag1_d;
            tag2_q  <= tag2_d;
            tag3_q  <= tag3_d;
            raw1_q  <= raw1_d;
            data3_q <= data3_d;
        end
    end

`ifdef MOD_ALU_RANGE_CHECK_EN
    localparam logic [W-1:0] Q_W = W'(Q);

    logic err_in, err1_q, err1_d, err2_q, err2_d, err3_q, err3_d;

    always_comb begin
        err_in = (in_a >= Q_W) || ((op_in != OP_RED) && (in_b >= Q_W));
        err1_d = ld1 ? err_in : err1_q;
        err2_d = ld2 ? err1_q : err2_q;
        err3_d = ld3 ? err2_q : err3_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err1_q <= 1'b0;
            err2_q <= 1'b0;
            err3_q <= 1'b0;
        end else begin
            err1_q <= err1_d;
            err2_q <= err2_d;
            err3_q <= err3_d;
        end
    end

    assign out_err = err3_q;
`else
    assign out_err = 1'b0;
`endif

    assign in_ready  = rdy1;
    assign out_valid = v3_q;
    assign out_data  = data3_q;
    assign out_tag   = tag3_q;

endmodule

// File: tb/tb_mod_alu_pipe.sv
// tb/tb_mod_alu_pipe.sv - directed and streaming self-checking bench for mod_alu_pipe
module tb_mod_alu_pipe;
    import mod_alu_pkg::*;

    localparam int W     = 16;
    localparam int Q     = KYBER_Q;
    localparam int TAG_W = 8;
    localparam int RINV  = 169;   // 2^-16 mod 3329

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, out_valid, out_ready, out_err;
    logic [1:0]       in_op;
    logic [W-1:0]     in_a, in_b, out_data;
    logic [TAG_W-1:0] in_tag, out_tag;

    int checks = 0;
    int errors = 0;

    int d_op  [12] = '{0, 0, 1, 0, 2, 2, 2, 2, 3, 0, 3, 1};
    int d_a   [12] = '{100, 3000, 100, 3328, 0, 20, MONT_R_MOD_Q, 3328, MONT_R_MOD_Q, 3329, 5, 0};
    int d_b   [12] = '{200, 1000, 200, 3328, 1234, 50, 1234, 3328, 999, 0, 4000, 3328};
    int d_exp [12] = '{300, 671, 3229, 3327, 0, 2550, 1234, 169, 1, 0, 845, 1};
    int d_err [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};

    always #5 clk = ~clk;

    mod_alu_pipe #(
        .W     (W),
        .Q     (Q),
        .QINV  (KYBER_QINV),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    function automatic logic [W-1:0] model(input logic [1:0] op, input int a, input int b);
        int r;
        case (op)
            2'd0:    r = (a + b) % Q;
            2'd1:    r = (a - b + Q) % Q;
            2'd2:    r = (((a * b) % Q) * RINV) % Q;
            default: r = (a * RINV) % Q;
        endcase
        return W'(r);
    endfunction

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 16'd0) begin errors++; $display("FAIL reset_out_data got %0d want 0", out_data); end
        checks++; if (out_tag !== 8'd0) begin errors++; $display("FAIL reset_out_tag got %0d want 0", out_tag); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %b want 0", out_err); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed_ops;
        int   edges;
        logic got;
        logic exp_err;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_op = 2'(d_op[i]); in_a = W'(d_a[i]); in_b = W'(d_b[i]);
            in_tag = TAG_W'(8'hA0 + i); out_ready = 1'b1;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir_in_ready vec %0d got %b want 1", i, in_ready); end
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            edges = 1; got = 1'b0;
            while (!got && edges < 10) begin
                if (out_valid === 1'b1) got = 1'b1;
                else begin @(negedge clk); edges++; end
            end
`ifdef MOD_ALU_RANGE_CHECK_EN
            exp_err = (d_err[i] != 0);
`else
            exp_err = 1'b0;
`endif
            checks++; if (edges != 3) begin errors++; $display("FAIL dir_latency vec %0d got %0d want 3", i, edges); end
            checks++; if (out_data !== W'(d_exp[i])) begin errors++; $display("FAIL dir_data vec %0d got %0d want %0d", i, out_data, d_exp[i]); end
            checks++; if (out_tag !== TAG_W'(8'hA0 + i)) begin errors++; $display("FAIL dir_tag vec %0d got %0h want %0h", i, out_tag, 8'hA0 + i); end
            checks++; if (out_err !== exp_err) begin errors++; $display("FAIL dir_err vec %0d got %b want %b", i, out_err, exp_err); end
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0]   op_v [16];
        int           a_v [16], b_v [16];
        logic [W-1:0] exp_v [16];
        int sent = 0, recv = 0, cyc = 0, first = -1, last = -1;
        for (int i = 0; i < 16; i++) begin
            op_v[i] = 2'(i % 4);
            a_v[i]  = (i * 397 + 11) % Q;
            b_v[i]  = (i * 1013 + 5) % Q;
            exp_v[i] = model(op_v[i], a_v[i], b_v[i]);
        end
        out_ready = 1'b1;
        while (recv < 16 && cyc < 100) begin
            @(negedge clk);
            if (sent < 16) begin
                in_valid = 1'b1; in_op = op_v[sent]; in_a = W'(a_v[sent]); in_b = W'(b_v[sent]); in_tag = TAG_W'(sent);
            end else in_valid = 1'b0;
            #1;
            if (sent < 16) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cyc %0d got %b want 1", cyc, in_ready); end
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (out_data !== exp_v[recv] || out_tag !== TAG_W'(recv)) begin
                    errors++; $display("FAIL b2b_result %0d got %0d/%0d want %0d/%0d", recv, out_data, out_tag, exp_v[recv], recv);
                end
                if (first < 0) first = cyc;
                last = cyc;
                recv++;
            end
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (recv != 16 || first != 3 || last - first != 15) begin
            errors++; $display("FAIL b2b_throughput got recv %0d first %0d span %0d want 16 3 15", recv, first, last - first);
        end
    endtask

    task automatic test_backpressure;
        logic [1:0]       op_v [1000];
        int               a_v [1000], b_v [1000];
        logic [W-1:0]     exp_v [1000];
        int               sent = 0, recv = 0, cyc = 0, occ = 0, extra = 0;
        logic             prev_stall = 1'b0, hold = 1'b0;
        logic [W-1:0]     held_d = '0;
        logic [TAG_W-1:0] held_t = '0;
        for (int i = 0; i < 1000; i++) begin
            op_v[i]  = 2'($urandom_range(0, 3));
            a_v[i]   = $urandom_range(0, Q - 1);
            b_v[i]   = $urandom_range(0, Q - 1);
            exp_v[i] = model(op_v[i], a_v[i], b_v[i]);
        end
        while (recv < 1000 && cyc < 6000) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 9) >= 3);
            if (sent < 1000 && (hold || $urandom_range(0, 9) < 8)) begin
                in_valid = 1'b1; in_op = op_v[sent]; in_a = W'(a_v[sent]); in_b = W'(b_v[sent]); in_tag = TAG_W'(sent);
            end else in_valid = 1'b0;
            #1;
            checks++; if (in_ready !== !(occ == 3 && !out_ready)) begin
                errors++; $display("FAIL bp_in_ready cyc %0d got %b occupancy %0d out_ready %b", cyc, in_ready, occ, out_ready);
            end
            if (prev_stall) begin
                checks++; if (out_valid !== 1'b1 || out_data !== held_d || out_tag !== held_t) begin
                    errors++; $display("FAIL bp_stable cyc %0d got %b %0d/%0d want 1 %0d/%0d", cyc, out_valid, out_data, out_tag, held_d, held_t);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++; if (out_data !== exp_v[recv] || out_tag !== TAG_W'(recv)) begin
                    errors++; $display("FAIL bp_result %0d got %0d/%0d want %0d/%0d", recv, out_data, out_tag, exp_v[recv], TAG_W'(recv));
                end
                recv++;
            end
            prev_stall = out_valid && !out_ready;
            held_d = out_data;
            held_t = out_tag;
            hold = in_valid && !in_ready;
            occ = occ + ((in_valid && in_ready) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) extra++;
        end
        checks++; if (recv != 1000 || extra != 0) begin
            errors++; $display("FAIL bp_count got %0d results %0d extra want 1000 0", recv, extra);
        end
    endtask

    task automatic test_reset_inflight;
        int   stale = 0, edges;
        logic got;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'd0; in_a = 16'd1; in_b = 16'd2; in_tag = 8'h55;
        @(negedge clk);
        in_op = 2'd2; in_a = 16'd20; in_b = 16'd50; in_tag = 8'h66;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %b want 1", out_valid); end
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'd0) begin
            errors++; $display("FAIL rst_async got valid %b ready %b data %0d want 0 1 0", out_valid, in_ready, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) stale++;
        end
        checks++; if (stale != 0) begin errors++; $display("FAIL rst_stale got %0d want 0", stale); end
        in_valid = 1'b1; in_op = 2'd1; in_a = 16'd10; in_b = 16'd20; in_tag = 8'h77;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        edges = 1; got = 1'b0;
        while (!got && edges < 10) begin
            if (out_valid === 1'b1) got = 1'b1;
            else begin @(negedge clk); edges++; end
        end
        checks++; if (edges != 3 || out_data !== 16'd3319 || out_tag !== 8'h77) begin
            errors++; $display("FAIL rst_first_op got lat %0d data %0d tag %0h want 3 3319 77", edges, out_data, out_tag);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed_ops();
        test_back_to_back();
        test_backpressure();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
